// File: rtl/nibble_frame_serializer_if.sv
// nibble_frame_serializer_if: nibble handshake in, serial frame stream and status out.
interface nibble_frame_serializer_if #(parameter int DEPTH = 4);
  logic [3:0] in_data;
  logic in_valid, in_ready, out, frame_start, out_is_idle;
  logic [$clog2(DEPTH):0] level;
  logic [7:0] underrun_cnt;
  modport master (output in_data, in_valid, input in_ready, out, frame_start, out_is_idle, level, underrun_cnt);
  modport slave (input in_data, in_valid, output in_ready, out, frame_start, out_is_idle, level, underrun_cnt);
endinterface

// File: rtl/nibble_frame_serializer.sv
// nibble_frame_serializer: FIFO-buffered nibbles sent MSB-first in 4-cycle frames, filler when empty.
// Optional underrun counter enabled by NIBBLE_SERIALIZER_UNDERRUN_CNT_EN.
module nibble_frame_serializer #(
  parameter int DEPTH = 4,
  parameter logic [3:0] IDLE_NIBBLE = 4'b0000
) (
  input logic clk,
  input logic rst,
  nibble_frame_serializer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  logic [3:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] shreg_q, shreg_d;
  logic idle_q, idle_d, push, pop;
  assign bus.in_ready = level_q < LW'(DEPTH);
  assign push = bus.in_valid && bus.in_ready;
  // pop uses pre-push occupancy, so a nibble arriving on a boundary edge waits a frame
  assign pop = (cnt_q == 2'd3) && (level_q != '0);
  assign bus.out = shreg_q[3];
  assign bus.frame_start = cnt_q == 2'd0;
  assign bus.out_is_idle = idle_q;
  assign bus.level = level_q;
  always_comb begin
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    level_d = level_q + LW'(push) - LW'(pop);
    cnt_d = cnt_q + 2'd1;
    shreg_d = cnt_q != 2'd3 ? {shreg_q[2:0], 1'b0} : pop ? mem_q[rd_q] : IDLE_NIBBLE;
    idle_d = cnt_q == 2'd3 ? !pop : idle_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
      cnt_q <= '0;
      shreg_q <= IDLE_NIBBLE;
      idle_q <= 1'b1;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
      cnt_q <= cnt_d;
      shreg_q <= shreg_d;
      idle_q <= idle_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.in_data;
  end
`ifdef NIBBLE_SERIALIZER_UNDERRUN_CNT_EN
  logic [7:0] ur_q, ur_d;
  assign ur_d = (cnt_q == 2'd3 && !pop && ur_q != 8'hff) ? ur_q + 8'd1 : ur_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ur_q <= '0;
    else ur_q <= ur_d;
  end
  assign bus.underrun_cnt = ur_q;
`else
  assign bus.underrun_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_nibble_frame_serializer.sv
// tb_nibble_frame_serializer: directed stimulus, expected frames queued, negedge monitor compares.
module tb_nibble_frame_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  nibble_frame_serializer_if #(.DEPTH(4)) bus ();
  nibble_frame_serializer #(.DEPTH(4), .IDLE_NIBBLE(4'b0000)) dut (.clk(clk), .rst(rst), .bus(bus));
`ifdef NIBBLE_SERIALIZER_UNDERRUN_CNT_EN
  localparam bit UR = 1'b1;
`else
  localparam bit UR = 1'b0;
`endif
  localparam logic [4:0] FILL = 5'b10000;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [4:0] exp_q[$];
  logic [3:0] d4 [6] = '{4'hA, 4'hC, 4'h3, 4'hF, 4'h1, 4'h8};
  logic [3:0] d6 [4] = '{4'hF, 4'h2, 4'h4, 4'h6};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
    cyc += n;
  endtask

  task automatic reset_checks();
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out", 32'(bus.out), 0);
    chk("rst_frame_start", 32'(bus.frame_start), 1);
    chk("rst_out_is_idle", 32'(bus.out_is_idle), 1);
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_underrun", 32'(bus.underrun_cnt), 0);
  endtask

  task automatic do_reset();
    chk("drained", 32'(exp_q.size()), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    bus.in_valid = 1'b0;
    #1 reset_checks();
    @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
  endtask

  int nb = 0;
  logic [3:0] sh;
  logic idl, same;
  logic [4:0] e;
  always @(negedge clk) begin
    if (rst) nb = 0;
    else begin
      if (bus.frame_start) begin
        if (nb != 0) begin
          checks++;
          errors++;
          $display("FAIL frame_align: frame_start after %0d bits, expected after 4", nb);
        end
        sh = {3'b000, bus.out};
        idl = bus.out_is_idle;
        same = 1'b1;
        nb = 1;
      end else if (nb != 0) begin
        sh = {sh[2:0], bus.out};
        same &= (bus.out_is_idle == idl);
        nb++;
      end
      if (nb == 4) begin
        nb = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got idle=%0b data=%b, expected no frame", idl, sh);
        end else begin
          e = exp_q.pop_front();
          chk("frame {steady,idle,data}", {26'd0, same, idl, sh}, {26'd0, 1'b1, e});
        end
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 4'h0;
    // idle stream: fillers at cycles 0,4,8
    do_reset();
    repeat (3) exp_q.push_back(FILL);
    step(9);
    chk("underrun_c9", 32'(bus.underrun_cnt), UR ? 2 : 0);
    step(3);
    chk("underrun_c12", 32'(bus.underrun_cnt), UR ? 3 : 0);
    // single match nibble pushed at phase 0
    do_reset();
    exp_q.push_back(FILL);
    exp_q.push_back(5'b00111);
    exp_q.push_back(FILL);
    bus.in_data = 4'b0111;
    bus.in_valid = 1'b1;
    step(1);
    bus.in_valid = 1'b0;
    chk("t2_level", 32'(bus.level), 1);
    step(11);
    // back-to-back from phase 1
    do_reset();
    exp_q.push_back(FILL);
    exp_q.push_back(5'b01001);
    exp_q.push_back(5'b01110);
    exp_q.push_back(5'b00101);
    step(1);
    bus.in_valid = 1'b1;
    bus.in_data = 4'b1001;
    step(1);
    bus.in_data = 4'b1110;
    step(1);
    bus.in_data = 4'b0101;
    step(1);
    bus.in_valid = 1'b0;
    chk("t3_level_c4", 32'(bus.level), 2);
    step(4);
    chk("t3_level_c8", 32'(bus.level), 1);
    step(4);
    chk("t3_level_c12", 32'(bus.level), 0);
    step(4);
    // fill to full, backpressure
    do_reset();
    exp_q.push_back(FILL);
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, d4[i]});
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = d4[i];
      step(1);
    end
    bus.in_data = d4[5];
    chk("t4_level_full", 32'(bus.level), 4);
    chk("t4_ready_c5", 32'(bus.in_ready), 0);
    step(2);
    chk("t4_ready_c7", 32'(bus.in_ready), 0);
    step(1);
    chk("t4_ready_c8", 32'(bus.in_ready), 1);
    chk("t4_level_c8", 32'(bus.level), 3);
    step(1);
    bus.in_valid = 1'b0;
    chk("t4_level_c9", 32'(bus.level), 4);
    step(19);
    // push on the phase-3 edge: filler first, 5-cycle latency
    do_reset();
    exp_q.push_back(FILL);
    exp_q.push_back(FILL);
    exp_q.push_back(5'b01101);
    step(3);
    bus.in_data = 4'b1101;
    bus.in_valid = 1'b1;
    step(1);
    bus.in_valid = 1'b0;
    step(8);
    // asynchronous reset in the middle of a data frame
    do_reset();
    exp_q.push_back(FILL);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = d6[i];
      step(1);
    end
    bus.in_valid = 1'b0;
    chk("t6_level", 32'(bus.level), 3);
    step(1);
    #2;
    chk("t6_out_mid", 32'(bus.out), 1);
    chk("drained", 32'(exp_q.size()), 0);
    rst = 1'b1;
    #1 reset_checks();
    exp_q.delete();
    exp_q.push_back(FILL);
    exp_q.push_back(FILL);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
    chk("t6_frame_start_c0", 32'(bus.frame_start), 1);
    step(8);
    chk("drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
